// File: rtl/pack_leb128_if.sv
// Handshake bundle for the LEB128 encoder: one value in, a stream of bytes out.
interface pack_leb128_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 4
);
    logic [DATA_W-1:0] in_value;
    logic              in_signed;
    logic              in_is32;
    logic              in_stb;
    logic              in_ack;
    logic [7:0]        out_byte;
    logic              out_last;
    logic              out_stb;
    logic              out_ack;
    logic [CNT_W-1:0]  out_count;

    // Producer of values / consumer of bytes
    modport master (
        output in_value, in_signed, in_is32, in_stb, out_ack,
        input  in_ack, out_byte, out_last, out_stb, out_count
    );

    // The encoder itself
    modport slave (
        input  in_value, in_signed, in_is32, in_stb, out_ack,
        output in_ack, out_byte, out_last, out_stb, out_count
    );
endinterface

// File: rtl/pack_leb128.sv
// Sequential LEB128 encoder: latches one integer, then streams its encoding
// LSB group first, one byte per out handshake. Signed and unsigned, 32/64-bit.
module pack_leb128 #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 4
) (
    input  logic         clk,
    input  logic         reset,
    pack_leb128_if.slave bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] v_q, v_d;
    logic              sgn_q, sgn_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] ext_v;
    logic [DATA_W-1:0] rest;
    logic              last;

    // Widen the incoming value: 32-bit inputs ignore in_value[DATA_W-1:32]
    always_comb begin
        ext_v = bus.in_value;
        if (bus.in_is32) begin
            if (bus.in_signed) ext_v = DATA_W'($signed(bus.in_value[31:0]));
            else               ext_v = DATA_W'(bus.in_value[31:0]);
        end
    end

    // Remaining groups after this byte and the termination test
    always_comb begin
        if (sgn_q) rest = DATA_W'($signed(v_q) >>> 7);
        else       rest = v_q >> 7;
        if (sgn_q) last = ((rest == '0) && !v_q[6]) || ((rest == '1) && v_q[6]);
        else       last = (rest == '0);
    end

    // State, working value and byte counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            v_q     <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: accept in IDLE, shift out one group per byte handshake in EMIT
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_stb) begin
                    v_d     = ext_v;
                    sgn_d   = bus.in_signed;
                    cnt_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ack) begin
                    // In IDLE the counter then reads as the encoded length
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last) state_d = IDLE;
                    else      v_d     = rest;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; byte/last forced to zero outside EMIT
    always_comb begin
        bus.in_ack    = (state_q == IDLE);
        bus.out_stb   = (state_q == EMIT);
        bus.out_byte  = (state_q == EMIT) ? {~last, v_q[6:0]} : 8'h00;
        bus.out_last  = (state_q == EMIT) && last;
        bus.out_count = cnt_q;
    end
endmodule

// File: tb/tb_pack_leb128.sv
// Self-checking bench for pack_leb128: directed vectors plus random values
// checked against a length-from-range LEB128 model.
module tb_pack_leb128;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    pack_leb128_if #(.DATA_W(64), .CNT_W(4)) bus ();
    pack_leb128 #(.DATA_W(64), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Encoding length is the smallest n whose 7n-bit range (two's complement
    // when signed) holds the value; byte i is group i plus a continuation flag.
    function automatic int model(input logic [63:0] val, input bit sgn, input bit is32,
                                 output logic [7:0] eb [10]);
        logic signed [127:0] x, lim;
        int n;
        if (is32) begin
            if (sgn) x = 128'($signed(val[31:0]));
            else     x = 128'(val[31:0]);
        end else begin
            if (sgn) x = 128'($signed(val));
            else     x = 128'(val);
        end
        n = 10;
        for (int k = 10; k >= 1; k--) begin
            lim = 128'sd1 <<< (7 * k - (sgn ? 1 : 0));
            if (sgn ? (x >= -lim && x < lim) : (x < lim)) n = k;
        end
        for (int i = 0; i < 10; i++) eb[i] = {(i < n - 1), x[7 * i +: 7]};
        return n;
    endfunction

    task automatic send(input logic [63:0] val, input bit sgn, input bit is32,
                        input bit bp, input string tag);
        logic [7:0] eb [10];
        int n, i, cyc;
        n = model(val, sgn, is32, eb);
        @(negedge clk);
        bus.in_value  = val;
        bus.in_signed = sgn;
        bus.in_is32   = is32;
        bus.in_stb    = 1'b1;
        cyc = 0;
        while (!bus.in_ack && cyc < 20) begin @(negedge clk); cyc++; end
        check({tag, " in_ack"}, 64'(bus.in_ack), 64'd1);
        @(posedge clk);
        #1 bus.in_stb = 1'b0;
        bus.in_value = {$urandom, $urandom};
        i = 0; cyc = 0;
        while (i < n && cyc < 200) begin
            @(negedge clk); cyc++;
            check({tag, " out_stb"},   64'(bus.out_stb),   64'd1);
            check({tag, " out_byte"},  64'(bus.out_byte),  64'(eb[i]));
            check({tag, " out_last"},  64'(bus.out_last),  64'(i == n - 1));
            check({tag, " out_count"}, 64'(bus.out_count), 64'(i));
            check({tag, " busy_ack"},  64'(bus.in_ack),    64'd0);
            bus.out_ack = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            if (bus.out_ack) i++;
            #1 bus.out_ack = 1'b0;
        end
        check({tag, " done"}, 64'(i), 64'(n));
        @(negedge clk);
        check({tag, " idle_stb"}, 64'(bus.out_stb),   64'd0);
        check({tag, " idle_ack"}, 64'(bus.in_ack),    64'd1);
        check({tag, " length"},   64'(bus.out_count), 64'(n));
    endtask

    initial begin
        logic [63:0] r;
        bit s, w;
        reset = 1'b1;
        bus.in_value = '0; bus.in_signed = 1'b0; bus.in_is32 = 1'b0;
        bus.in_stb = 1'b0; bus.out_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst in_ack",    64'(bus.in_ack),    64'd1);
        check("rst out_stb",   64'(bus.out_stb),   64'd0);
        check("rst out_byte",  64'(bus.out_byte),  64'd0);
        check("rst out_last",  64'(bus.out_last),  64'd0);
        check("rst out_count", 64'(bus.out_count), 64'd0);

        // Directed vectors
        send(64'd624485, 0, 0, 0, "u624485");
        check("u624485 len", 64'(bus.out_count), 64'd3);
        send(-64'sd123456, 1, 0, 0, "s-123456");
        send(64'd64, 1, 0, 0, "s64");
        send(64'd63, 1, 0, 0, "s63");
        send('1, 1, 0, 0, "s-1");
        send(-64'sd64, 1, 0, 0, "s-64");
        send(-64'sd65, 1, 0, 0, "s-65");
        send(64'd0, 0, 0, 0, "u0");
        send(64'd0, 1, 0, 0, "s0");
        send(64'hDEAD_BEEF_FFFF_FFFF, 0, 1, 0, "u32max");
        send(64'h1234_5678_FFFF_FFFF, 1, 1, 0, "s32-1");
        send(64'hABCD_0000_8000_0000, 1, 1, 0, "s32min");
        send('1, 0, 0, 0, "u64max");
        send(64'h8000_0000_0000_0000, 1, 0, 1, "s64min");

        // Backpressure on 300 with in_stb held high the whole time
        @(negedge clk);
        bus.in_value = 64'd300; bus.in_signed = 1'b0; bus.in_is32 = 1'b0; bus.in_stb = 1'b1;
        @(posedge clk);
        #1 bus.in_value = 64'd7;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp hold byte",  64'(bus.out_byte),  64'hAC);
            check("bp hold count", 64'(bus.out_count), 64'd0);
            check("bp no accept",  64'(bus.in_ack),    64'd0);
        end
        @(negedge clk);
        check("bp byte0", 64'(bus.out_byte), 64'hAC);
        bus.out_ack = 1'b1;
        @(negedge clk);
        check("bp byte1", 64'(bus.out_byte), 64'h02);
        check("bp last1", 64'(bus.out_last), 64'd1);
        check("bp busy",  64'(bus.in_ack),   64'd0);
        @(negedge clk);
        check("bp bubble ack", 64'(bus.in_ack),    64'd1);
        check("bp bubble stb", 64'(bus.out_stb),   64'd0);
        check("bp length",     64'(bus.out_count), 64'd2);
        @(negedge clk);
        bus.in_stb = 1'b0;
        check("bp 2nd byte", 64'(bus.out_byte), 64'h07);
        check("bp 2nd last", 64'(bus.out_last), 64'd1);
        @(negedge clk);
        bus.out_ack = 1'b0;
        check("bp 2nd done", 64'(bus.out_stb), 64'd0);

        // Reset while emitting byte 2 of a 10-byte encoding
        @(negedge clk);
        bus.in_value = '1; bus.in_signed = 1'b0; bus.in_is32 = 1'b0; bus.in_stb = 1'b1;
        @(negedge clk);
        bus.in_stb = 1'b0; bus.out_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst mid count", 64'(bus.out_count), 64'd2);
        reset = 1'b1; bus.out_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rst mid stb",   64'(bus.out_stb),   64'd0);
        check("rst mid ack",   64'(bus.in_ack),    64'd1);
        check("rst mid count0", 64'(bus.out_count), 64'd0);
        send(64'd5, 0, 0, 0, "after rst");

        // Random values of varied magnitude, sign, width and backpressure
        for (int t = 0; t < 40; t++) begin
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            r = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (s && $urandom_range(0, 1) == 1) r = -r;
            send(r, s, w, ($urandom_range(0, 2) == 0), "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
